// File: rtl/cic_comb_decimator.sv
// ---------------------------------------------------------------------------
// cic_comb_decimator
//
// Comb (differentiator) and decimation half of a CIC decimation filter. It
// takes one full-rate integrator sample per clk_in cycle, keeps every
// DECIM-th sample and runs it through STAGES registered comb sections, each
// computing y = x - x delayed by DIFF_DELAY decimated samples. Arithmetic is
// modulo 2^DIN_WIDTH on purpose: the integrators upstream wrap freely, and
// the comb differences cancel that wrap exactly.
//
// Ports
//   clk_in      in   clock, one input sample per rising edge
//   rst         in   synchronous reset, active-high
//   din         in   DIN_WIDTH   signed integrator output at full rate
//   dout        out  DOUT_WIDTH  signed decimated output (top bits of the
//                                last comb stage, truncated)
//   dout_valid  out  one-cycle strobe when dout holds a new sample
// ---------------------------------------------------------------------------
module cic_comb_decimator #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 32,
    parameter int STAGES     = 3,
    parameter int DECIM      = 8,
    parameter int DIFF_DELAY = 1
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic signed [DIN_WIDTH-1:0]  din,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    // Refuse to build an impossible configuration.
    if (DOUT_WIDTH > DIN_WIDTH || DECIM < 1 || STAGES < 1 ||
        (DIFF_DELAY != 1 && DIFF_DELAY != 2)) begin : g_cfg_err
        $error("cic_comb_decimator: invalid parameter combination");
    end

    // Wrapping two's-complement difference; overflow is intended.
    function automatic logic signed [DIN_WIDTH-1:0] wrap_sub(
        input logic signed [DIN_WIDTH-1:0] a,
        input logic signed [DIN_WIDTH-1:0] b
    );
        return a - b;
    endfunction

    // Keep the top DOUT_WIDTH bits, no rounding.
    function automatic logic signed [DOUT_WIDTH-1:0] trunc_out(
        input logic signed [DIN_WIDTH-1:0] a
    );
        return a[DIN_WIDTH-1 -: DOUT_WIDTH];
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Index 0 is the captured decimated sample (_p0); index j is comb stage j.
    logic signed [DIN_WIDTH-1:0] data_p_q [0:STAGES];
    logic signed [DIN_WIDTH-1:0] data_p_d [0:STAGES];
    logic                        vld_p_q  [0:STAGES];
    logic                        vld_p_d  [0:STAGES];

    // Per-stage delay line; element 0 is the most recent stage input.
    logic signed [DIN_WIDTH-1:0] dly_q [1:STAGES][0:DIFF_DELAY-1];
    logic signed [DIN_WIDTH-1:0] dly_d [1:STAGES][0:DIFF_DELAY-1];

    always_comb begin
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        data_p_d = data_p_q;
        vld_p_d  = vld_p_q;
        dly_d    = dly_q;

        // Stage p0: decimation capture.
        vld_p_d[0] = (cnt_q == CNT_LAST);
        if (cnt_q == CNT_LAST) begin
            data_p_d[0] = din;
        end

        // Stages p1..pSTAGES: comb sections, advancing only on a valid input
        // so the delay is counted in decimated samples, not clock cycles.
        for (int j = 1; j <= STAGES; j++) begin
            vld_p_d[j] = vld_p_q[j-1];
            if (vld_p_q[j-1]) begin
                data_p_d[j] = wrap_sub(data_p_q[j-1], dly_q[j][DIFF_DELAY-1]);
                dly_d[j][0] = data_p_q[j-1];
                for (int k = 1; k < DIFF_DELAY; k++) begin
                    dly_d[j][k] = dly_q[j][k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
            for (int j = 0; j <= STAGES; j++) begin
                data_p_q[j] <= '0;
                vld_p_q[j]  <= 1'b0;
            end
            for (int j = 1; j <= STAGES; j++) begin
                for (int k = 0; k < DIFF_DELAY; k++) begin
                    dly_q[j][k] <= '0;
                end
            end
        end else begin
            cnt_q    <= cnt_d;
            data_p_q <= data_p_d;
            vld_p_q  <= vld_p_d;
            dly_q    <= dly_d;
        end
    end

    // The last stage register only moves on the edge that raises its valid,
    // so it already holds its value between strobes.
    assign dout       = trunc_out(data_p_q[STAGES]);
    assign dout_valid = vld_p_q[STAGES];

endmodule

// File: tb/tb_cic_comb_decimator.sv
// ---------------------------------------------------------------------------
// tb_cic_comb_decimator
//
// Three DUT configurations share clock, reset and a 32-bit stimulus word:
//   A: defaults (STAGES=3, DECIM=8, M=1, 32 -> 32)
//   B: STAGES=2, DECIM=4, M=2, 16 -> 12 (output truncation)
//   C: STAGES=1, DECIM=1, M=1, 8 -> 8 (continuous strobe, wrap)
// The reference model evaluates the comb cascade in closed form,
// y[n] = sum_i (-1)^i C(S,i) x[n - i*M], over the captured samples.
// ---------------------------------------------------------------------------
module tb_cic_comb_decimator;

    localparam int A_S = 3, A_D = 8, A_M = 1, A_W = 32, A_OW = 32;
    localparam int B_S = 2, B_D = 4, B_M = 2, B_W = 16, B_OW = 12;
    localparam int C_S = 1, C_D = 1, C_M = 1, C_W = 8,  C_OW = 8;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    logic        clk_in;
    logic        rst;
    logic [31:0] din_raw;
    logic        started;

    logic signed [A_W-1:0]  a_din;
    logic signed [B_W-1:0]  b_din;
    logic signed [C_W-1:0]  c_din;
    logic signed [A_OW-1:0] a_dout;
    logic signed [B_OW-1:0] b_dout;
    logic signed [C_OW-1:0] c_dout;
    logic                   a_vld, b_vld, c_vld;

    assign a_din = din_raw;
    assign b_din = din_raw[B_W-1:0];
    assign c_din = din_raw[C_W-1:0];

    cic_comb_decimator #(.DIN_WIDTH(A_W), .DOUT_WIDTH(A_OW), .STAGES(A_S),
                         .DECIM(A_D), .DIFF_DELAY(A_M)) u_a (
        .clk_in(clk_in), .rst(rst), .din(a_din), .dout(a_dout), .dout_valid(a_vld));
    cic_comb_decimator #(.DIN_WIDTH(B_W), .DOUT_WIDTH(B_OW), .STAGES(B_S),
                         .DECIM(B_D), .DIFF_DELAY(B_M)) u_b (
        .clk_in(clk_in), .rst(rst), .din(b_din), .dout(b_dout), .dout_valid(b_vld));
    cic_comb_decimator #(.DIN_WIDTH(C_W), .DOUT_WIDTH(C_OW), .STAGES(C_S),
                         .DECIM(C_D), .DIFF_DELAY(C_M)) u_c (
        .clk_in(clk_in), .rst(rst), .din(c_din), .dout(c_dout), .dout_valid(c_vld));

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // valid flag at bit 40, output value zero-extended below it
    function automatic logic [63:0] pack(input logic v, input logic [63:0] d);
        return (64'(v) << 40) | d;
    endfunction

    // h[0] is the newest captured sample, h[i] the one i decimated samples ago.
    function automatic logic [63:0] comb_model(input logic [63:0] h [0:8],
                                               input int s, input int m,
                                               input int w, input int ow);
        logic [63:0] acc;
        logic [63:0] c;
        acc = '0;
        c   = 64'd1;
        for (int i = 0; i <= s; i++) begin
            if (i % 2 == 0) acc = acc + c * h[i*m];
            else            acc = acc - c * h[i*m];
            c = c * 64'(s - i) / 64'(i + 1);
        end
        acc = acc & mask(w);
        return acc >> (w - ow);
    endfunction

    // ---------------- scoreboard A ----------------
    logic [63:0] ha [0:8];
    exp_t        qa [$];
    exp_t        ea;
    int          ka = 0, pa = 0;
    logic [63:0] la = '0;

    always @(negedge clk_in) begin
        if (started) begin
            if (qa.size() != 0 && qa[0].cyc == ka) begin
                ea = qa.pop_front();
                la = ea.val;
                pa++;
                check_val("A_pulse", pack(a_vld, 64'($unsigned(a_dout))), pack(1'b1, ea.val));
            end else begin
                check_val("A_idle", pack(a_vld, 64'($unsigned(a_dout))), pack(1'b0, la));
            end
        end
        if (rst) begin
            qa.delete();
            la = '0;
            ka = 0;
            for (int i = 0; i < 9; i++) ha[i] = '0;
        end else begin
            if (ka % A_D == A_D - 1) begin
                for (int i = 8; i > 0; i--) ha[i] = ha[i-1];
                ha[0] = 64'(din_raw) & mask(A_W);
                qa.push_back('{cyc: ka + A_S + 1, val: comb_model(ha, A_S, A_M, A_W, A_OW)});
            end
            ka++;
        end
    end

    // ---------------- scoreboard B ----------------
    logic [63:0] hb [0:8];
    exp_t        qb [$];
    exp_t        eb;
    int          kb = 0, pb = 0;
    logic [63:0] lb = '0;

    always @(negedge clk_in) begin
        if (started) begin
            if (qb.size() != 0 && qb[0].cyc == kb) begin
                eb = qb.pop_front();
                lb = eb.val;
                pb++;
                check_val("B_pulse", pack(b_vld, 64'($unsigned(b_dout))), pack(1'b1, eb.val));
            end else begin
                check_val("B_idle", pack(b_vld, 64'($unsigned(b_dout))), pack(1'b0, lb));
            end
        end
        if (rst) begin
            qb.delete();
            lb = '0;
            kb = 0;
            for (int i = 0; i < 9; i++) hb[i] = '0;
        end else begin
            if (kb % B_D == B_D - 1) begin
                for (int i = 8; i > 0; i--) hb[i] = hb[i-1];
                hb[0] = 64'(din_raw) & mask(B_W);
                qb.push_back('{cyc: kb + B_S + 1, val: comb_model(hb, B_S, B_M, B_W, B_OW)});
            end
            kb++;
        end
    end

    // ---------------- scoreboard C ----------------
    logic [63:0] hc [0:8];
    exp_t        qc [$];
    exp_t        ec;
    int          kc = 0, pc = 0;
    logic [63:0] lc = '0;

    always @(negedge clk_in) begin
        if (started) begin
            if (qc.size() != 0 && qc[0].cyc == kc) begin
                ec = qc.pop_front();
                lc = ec.val;
                pc++;
                check_val("C_pulse", pack(c_vld, 64'($unsigned(c_dout))), pack(1'b1, ec.val));
            end else begin
                check_val("C_idle", pack(c_vld, 64'($unsigned(c_dout))), pack(1'b0, lc));
            end
        end
        if (rst) begin
            qc.delete();
            lc = '0;
            kc = 0;
            for (int i = 0; i < 9; i++) hc[i] = '0;
        end else begin
            if (kc % C_D == C_D - 1) begin
                for (int i = 8; i > 0; i--) hc[i] = hc[i-1];
                hc[0] = 64'(din_raw) & mask(C_W);
                qc.push_back('{cyc: kc + C_S + 1, val: comb_model(hc, C_S, C_M, C_W, C_OW)});
            end
            kc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic [31:0] d);
        @(posedge clk_in);
        #1;
        rst     = r;
        din_raw = d;
    endtask

    initial begin
        started = 1'b0;
        @(negedge clk_in);
        #1 started = 1'b1;
    end

    logic [31:0] acc1, acc2, acc3, wrap_v;

    initial begin
        rst     = 1'b1;
        din_raw = $urandom;
        // reset held for four edges with arbitrary din
        repeat (3) drive(1'b1, $urandom);

        // ramp din = k
        for (int k = 0; k < 60; k++) drive(1'b0, 32'(k));

        // step response of a three-integrator chain feeding the combs
        acc1 = '0; acc2 = '0; acc3 = '0;
        for (int k = 0; k < 120; k++) begin
            acc1 = acc1 + 32'd1;
            acc2 = acc2 + acc1;
            acc3 = acc3 + acc2;
            drive(1'b0, acc3);
        end

        // mid-run reset, then a +100 per cycle wrap ramp; 41 cycles after
        // release A has a sample sitting in its first comb stage
        drive(1'b1, $urandom);
        wrap_v = '0;
        for (int k = 0; k < 41; k++) begin
            drive(1'b0, wrap_v);
            wrap_v = wrap_v + 32'd100;
        end
        drive(1'b1, $urandom);
        for (int k = 0; k < 50; k++) drive(1'b0, $urandom);
        drive(1'b1, $urandom);
        for (int k = 0; k < 43; k++) drive(1'b0, $urandom);
        drive(1'b1, $urandom);

        // long random run with extreme values mixed in
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0:       drive(1'b0, 32'h7fff_ffff);
                1:       drive(1'b0, 32'h8000_0000);
                default: drive(1'b0, $urandom);
            endcase
        end
        repeat (20) drive(1'b0, 32'd0);
        @(negedge clk_in);
        #1;

        check_val("A_pulses_seen", 64'(pa > 30), 64'd1);
        check_val("B_pulses_seen", 64'(pb > 60), 64'd1);
        check_val("C_pulses_seen", 64'(pc > 300), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
